// File: rtl/lsu_if.sv
// Core request/response and memory port bundle for the load/store unit.
// The unit sits on the slave side; the core and memory share the master side.
interface lsu_if;
  localparam int unsigned XLEN = 32;

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_err_o;
  logic            mem_wen_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_wen_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_wen_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word accesses to a word-wide memory,
// sub-word stores done as read-modify-write, misaligned/illegal requests answered with an error.
module load_store_unit (
  input  logic clk_i,
  input  logic rst_i,
  lsu_if.slave bus
);
  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_wen_q, mem_wen_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_ILL:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [1:0] lo,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    unique case (lo)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    unique case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay store data onto the old word in its little-endian lane.
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                            input logic [1:0] lo, input logic [1:0] size);
    logic [XLEN-1:0] r;
    r = old;
    unique case (size)
      SZ_BYTE: begin
        unique case (lo)
          2'd0: r[7:0]   = wd[7:0];
          2'd1: r[15:8]  = wd[7:0];
          2'd2: r[23:16] = wd[7:0];
          2'd3: r[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_wdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d       = bus.req_we_i;
          size_d     = bus.req_size_i;
          unsigned_d = bus.req_unsigned_i;
          addr_d     = bus.req_addr_i;
          wdata_d    = bus.req_wdata_i;
          if (is_bad(bus.req_size_i, bus.req_addr_i[1:0])) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (!bus.req_we_i || bus.req_size_i != SZ_WORD) begin
            state_d = READ;
          end else begin
            state_d     = WRITE;
            mem_wdata_d = bus.req_wdata_i;
          end
        end
      end
      READ: begin
        // Sub-word stores reuse the read to build the full word to write back.
        if (we_q) begin
          state_d     = WRITE;
          mem_wdata_d = merge(bus.mem_rdata_i, wdata_q, addr_q[1:0], size_q);
        end else begin
          state_d      = RESP;
          resp_rdata_d = extract(bus.mem_rdata_i, addr_q[1:0], size_q, unsigned_q);
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_wen_d    = (state_d == WRITE);
    mem_addr_d   = (state_d == READ || state_d == WRITE) ? {addr_d[XLEN-1:2], 2'b00} : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.mem_wen_o    = mem_wen_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// compared against a word-array memory model with mask/shift access rules.
module tb_load_store_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  lsu_if bus ();

  load_store_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
  always @(posedge clk_i) if (bus.mem_wen_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    int          sh;
    int          bits;
    logic [31:0] mask;
    logic [31:0] v;
    if (size == 2'd2) return word;
    sh   = 8 * int'(addr[1:0]);
    bits = (size == 2'd0) ? 8 : 16;
    mask = (32'd1 << bits) - 32'd1;
    v    = (word >> sh) & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [31:0] addr);
    int          sh;
    logic [31:0] m;
    sh = 8 * int'(addr[1:0]);
    m  = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    m  = m << sh;
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
  endtask

  // One complete access: predict, issue, observe six cycles, compare.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        err_e;
    int          lat_e, wen_e, idx, guard;
    logic [31:0] rdata_e, word_e;
    int          resp_cyc, resp_cnt, wen_cnt, wen_cyc;
    logic [31:0] rd_seen, wd_seen, wa_seen;
    logic        err_seen;

    idx     = int'(addr[9:2]);
    err_e   = model_err(size, addr);
    word_e  = ref_mem[idx];
    rdata_e = 32'h0;
    wen_e   = 0;
    if (err_e) lat_e = 1;
    else if (!we) begin
      lat_e   = 2;
      rdata_e = model_load(ref_mem[idx], size, uns, addr);
    end else if (size == 2'd2) begin
      lat_e  = 2;
      wen_e  = 1;
      word_e = wdata;
    end else begin
      lat_e  = 3;
      wen_e  = 2;
      word_e = model_merge(ref_mem[idx], wdata, size, addr);
    end
    ref_mem[idx] = word_e;

    guard = 0;
    while (bus.req_ready_o !== 1'b1 && guard < 10) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check({tag, " ready"}, 32'(bus.req_ready_o), 32'd1);

    drive_req(we, size, uns, addr, wdata);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;

    resp_cyc = 0; resp_cnt = 0; wen_cnt = 0; wen_cyc = 0;
    rd_seen = '0; wd_seen = '0; wa_seen = '0; err_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_wen_o) begin
        wen_cnt++;
        wen_cyc = c;
        wd_seen = bus.mem_wdata_o;
        wa_seen = bus.mem_addr_o;
      end
      if (bus.resp_valid_o) begin
        resp_cnt++;
        if (resp_cyc == 0) begin
          resp_cyc = c;
          rd_seen  = bus.resp_rdata_o;
          err_seen = bus.resp_err_o;
        end
      end
      if (c < 6) begin
        @(posedge clk_i); #1;
      end
    end

    check({tag, " resp_cycle"}, 32'(resp_cyc), 32'(lat_e));
    check({tag, " resp_count"}, 32'(resp_cnt), 32'd1);
    check({tag, " err"}, 32'(err_seen), 32'(err_e));
    check({tag, " rdata"}, rd_seen, rdata_e);
    check({tag, " wen_cycle"}, 32'(wen_cyc), 32'(wen_e));
    check({tag, " wen_count"}, 32'(wen_cnt), (wen_e != 0) ? 32'd1 : 32'd0);
    if (wen_e != 0) begin
      check({tag, " wdata"}, wd_seen, word_e);
      check({tag, " waddr"}, wa_seen, {addr[31:2], 2'b00});
    end
    check({tag, " mem"}, mem[idx], ref_mem[idx]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, 32'(bus.req_ready_o), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata_o, 32'd0);
    check({tag, " resp_err"}, 32'(bus.resp_err_o), 32'd0);
    check({tag, " mem_wen"}, 32'(bus.mem_wen_o), 32'd0);
    check({tag, " mem_addr"}, bus.mem_addr_o, 32'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[32'h100 >> 2] = 32'h1122_3344;
    ref_mem[32'h104 >> 2] = 32'h8899_AABB;
    ref_mem[32'h108 >> 2] = 32'h0;
    ref_mem[32'h10C >> 2] = 32'h1234_5678;
    ref_mem[32'h110 >> 2] = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];

    // Reset state
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Sign/zero extended loads
    run_op("lb_104",  1'b0, 2'd0, 1'b0, 32'h104, 32'h0);
    run_op("lbu_104", 1'b0, 2'd0, 1'b1, 32'h104, 32'h0);
    run_op("lhu_106", 1'b0, 2'd1, 1'b1, 32'h106, 32'h0);
    run_op("lh_106",  1'b0, 2'd1, 1'b0, 32'h106, 32'h0);

    // Half store read-modify-write, then error cases
    run_op("sh_102",  1'b1, 2'd1, 1'b0, 32'h102, 32'hDEAD_BEEF);
    run_op("lw_101",  1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    run_op("ill_100", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    run_op("sh_odd",  1'b1, 2'd1, 1'b0, 32'h103, 32'h1234);

    // Word store with a load held valid behind it
    begin
      int ready_low;
      int guard;
      guard = 0;
      while (bus.req_ready_o !== 1'b1 && guard < 10) begin
        @(posedge clk_i); #1;
        guard++;
      end
      ref_mem[32'h108 >> 2] = 32'hCAFE_BABE;
      drive_req(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFE_BABE);
      @(posedge clk_i); #1;
      drive_req(1'b0, 2'd2, 1'b0, 32'h108, 32'h0);
      ready_low = 0;
      if (bus.req_ready_o == 1'b0) ready_low++;
      @(posedge clk_i); #1;
      if (bus.req_ready_o == 1'b0) ready_low++;
      check("b2b store_resp_c2", 32'(bus.resp_valid_o), 32'd1);
      check("b2b ready_low_c1_c2", 32'(ready_low), 32'd2);
      @(posedge clk_i); #1;
      check("b2b ready_c3", 32'(bus.req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      bus.req_valid_i = 1'b0;
      check("b2b ready_c4", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk_i); #1;
      check("b2b load_resp_c5", 32'(bus.resp_valid_o), 32'd1);
      check("b2b load_rdata_c5", bus.resp_rdata_o, 32'hCAFE_BABE);
      @(posedge clk_i); #1;
    end

    // Reset while a byte store is in its read phase
    begin
      int wen_seen;
      int resp_seen;
      drive_req(1'b1, 2'd0, 1'b0, 32'h10C, 32'h55);
      @(posedge clk_i); #1;
      bus.req_valid_i = 1'b0;
      check("rst_mid in_read", bus.mem_addr_o, 32'h10C);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check_idle_outputs("rst_mid");
      wen_seen = 0; resp_seen = 0;
      for (int c = 0; c < 4; c++) begin
        if (bus.mem_wen_o) wen_seen++;
        if (bus.resp_valid_o) resp_seen++;
        @(posedge clk_i); #1;
      end
      check("rst_mid wen_after", 32'(wen_seen), 32'd0);
      check("rst_mid resp_after", 32'(resp_seen), 32'd0);
      check("rst_mid mem_10c", mem[32'h10C >> 2], 32'h1234_5678);
    end

    // Byte lanes assembled into one word
    run_op("sb_110_0", 1'b1, 2'd0, 1'b0, 32'h110, 32'hFFFF_FF01);
    run_op("sb_110_1", 1'b1, 2'd0, 1'b0, 32'h111, 32'h0000_0002);
    run_op("sb_110_2", 1'b1, 2'd0, 1'b0, 32'h112, 32'hABCD_EF03);
    run_op("sb_110_3", 1'b1, 2'd0, 1'b0, 32'h113, 32'h0000_0004);
    run_op("lw_110",   1'b0, 2'd2, 1'b0, 32'h110, 32'h0);
    check("lw_110 word", ref_mem[32'h110 >> 2], 32'h0403_0201);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      run_op("rand", we, size, uns, addr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
